// File: rtl/descramble_ctrl_pkg.sv
// Shared types for the receive descrambler sequencing controller.
//   rate_speed_e : PIPE link rate; anything below RATE_GEN3 uses 8b/10b framing.
package descramble_ctrl_pkg;

    typedef enum logic [2:0] {
        RATE_GEN1 = 3'd0,
        RATE_GEN2 = 3'd1,
        RATE_GEN3 = 3'd2,
        RATE_GEN4 = 3'd3,
        RATE_GEN5 = 3'd4
    } rate_speed_e;

endpackage

// File: rtl/descramble_ctrl.sv
// Per-lane descrambler sequencing controller. For every 32-bit word (4 symbols)
// it tells the descrambler, per symbol, whether to reseed, advance or bypass
// the LFSR. Gen1/Gen2 decode 8b/10b K symbols; Gen3+ track 128b/130b blocks.
// All outputs are registered and describe the word presented one cycle earlier.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   curr_data_rate_i     : current link rate
//   data_valid_i         : word qualifier
//   data_in_i/data_k_in_i: 4 symbols ([7:0] first) and their K flags
//   sync_header_i        : 130b sync header, valid with block_start_i
//   block_start_i        : current word is word 0 of a block
//   seed_load_o/advance_o/bypass_o : per-symbol LFSR controls
//   block_type_o         : 0 none, 1 data, 2 ordered set, 3 EIEOS
//   word_idx_o           : word index within a Gen3 block
//   aligned_o            : Gen3 block lock
//   hdr_err_o/hdr_err_cnt_o : illegal sync header pulse / saturating count
module descramble_ctrl
    import descramble_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  rate_speed_e curr_data_rate_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_in_i,
    input  logic [3:0]  data_k_in_i,
    input  logic [1:0]  sync_header_i,
    input  logic        block_start_i,
    output logic [3:0]  seed_load_o,
    output logic [3:0]  advance_o,
    output logic [3:0]  bypass_o,
    output logic [1:0]  block_type_o,
    output logic [1:0]  word_idx_o,
    output logic        aligned_o,
    output logic        hdr_err_o,
    output logic [7:0]  hdr_err_cnt_o
);

    localparam int unsigned SYM_W = 8;
    localparam int unsigned N_SYM = 4;

    localparam logic [7:0]  K_COM     = 8'hBC;
    localparam logic [7:0]  K_SKP     = 8'h1C;
    localparam logic [7:0]  OS_SKP    = 8'hAA;
    localparam logic [31:0] EIEOS_W0  = 32'hFF00FF00;

    typedef enum logic [1:0] {
        UNALIGNED = 2'd0,
        DATA_BLK  = 2'd1,
        OS_BLK    = 2'd2,
        EIEOS_BLK = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  word_idx_q, word_idx_d;
    rate_speed_e rate_q;
    logic        skp_os_q, skp_os_d;
    logic        seed_pend_q, seed_pend_d;
    logic [7:0]  hdr_err_cnt_q, hdr_err_cnt_d;

    logic [3:0]  seed_load_q, seed_load_d;
    logic [3:0]  advance_q, advance_d;
    logic [3:0]  bypass_q, bypass_d;
    logic [1:0]  block_type_q, block_type_d;
    logic [1:0]  word_idx_out_q;
    logic        aligned_q, aligned_d;
    logic        hdr_err_q, hdr_err_d;

    logic        gen3_mode;
    logic        rate_chg;

    assign gen3_mode = (curr_data_rate_i >= RATE_GEN3);
    assign rate_chg  = (curr_data_rate_i != rate_q);

    // Block-framing FSM, reseed bookkeeping and per-symbol control decode.
    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        skp_os_d      = skp_os_q;
        seed_pend_d   = seed_pend_q;
        hdr_err_cnt_d = hdr_err_cnt_q;
        hdr_err_d     = 1'b0;
        seed_load_d   = '0;
        advance_d     = '0;
        bypass_d      = '0;
        block_type_d  = 2'd0;
        aligned_d     = 1'b0;

        // A rate change takes precedence over any header seen in the same cycle.
        if (rate_chg || !gen3_mode) begin
            state_d    = UNALIGNED;
            word_idx_d = 2'd0;
            if (rate_chg) begin
                seed_pend_d = 1'b1;
            end
        end else if (data_valid_i) begin
            if (block_start_i) begin
                // Block start always resynchronises, early starts are realigns.
                word_idx_d = 2'd0;
                unique case (sync_header_i)
                    2'b10: state_d = DATA_BLK;
                    2'b01: begin
                        state_d  = (data_in_i == EIEOS_W0) ? EIEOS_BLK : OS_BLK;
                        skp_os_d = (data_in_i[SYM_W-1:0] == OS_SKP);
                    end
                    default: begin
                        state_d   = UNALIGNED;
                        hdr_err_d = 1'b1;
                        if (hdr_err_cnt_q != 8'hFF) begin
                            hdr_err_cnt_d = hdr_err_cnt_q + 8'd1;
                        end
                    end
                endcase
            end else if (state_q != UNALIGNED) begin
                // Word 3 must be followed by a block start, otherwise lock is lost.
                if (word_idx_q == 2'd3) begin
                    state_d    = UNALIGNED;
                    word_idx_d = 2'd0;
                end else begin
                    word_idx_d = word_idx_q + 2'd1;
                end
            end
        end

        if (data_valid_i) begin
            if (!gen3_mode) begin
                for (int i = 0; i < int'(N_SYM); i++) begin
                    if (data_k_in_i[i] && (data_in_i[SYM_W*i +: SYM_W] == K_COM)) begin
                        seed_load_d[i] = 1'b1;
                        bypass_d[i]    = 1'b1;
                    end else if (data_k_in_i[i] && (data_in_i[SYM_W*i +: SYM_W] == K_SKP)) begin
                        bypass_d[i]    = 1'b1;
                    end else if (data_k_in_i[i]) begin
                        advance_d[i]   = 1'b1;
                        bypass_d[i]    = 1'b1;
                    end else begin
                        advance_d[i]   = 1'b1;
                    end
                end
            end else begin
                unique case (state_d)
                    DATA_BLK:  advance_d = 4'hF;
                    OS_BLK: begin
                        bypass_d  = 4'hF;
                        advance_d = skp_os_d ? 4'h0 : 4'hF;
                    end
                    EIEOS_BLK: bypass_d = 4'hF;
                    default:   bypass_d = 4'hF;
                endcase
            end

            // Pending reseed lands on symbol 0 of the first valid word.
            if (seed_pend_q || rate_chg) begin
                seed_load_d[0] = 1'b1;
                seed_pend_d    = 1'b0;
            end
            // The block after an EIEOS starts from the seed.
            if (gen3_mode && !rate_chg && (state_d == EIEOS_BLK) && (word_idx_d == 2'd3)) begin
                seed_pend_d = 1'b1;
            end
        end

        aligned_d = (state_d != UNALIGNED);
        unique case (state_d)
            DATA_BLK:  block_type_d = 2'd1;
            OS_BLK:    block_type_d = 2'd2;
            EIEOS_BLK: block_type_d = 2'd3;
            default:   block_type_d = 2'd0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= UNALIGNED;
            word_idx_q     <= 2'd0;
            rate_q         <= curr_data_rate_i;
            skp_os_q       <= 1'b0;
            seed_pend_q    <= 1'b0;
            hdr_err_cnt_q  <= 8'd0;
            seed_load_q    <= 4'h0;
            advance_q      <= 4'h0;
            bypass_q       <= 4'hF;
            block_type_q   <= 2'd0;
            word_idx_out_q <= 2'd0;
            aligned_q      <= 1'b0;
            hdr_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_idx_q     <= word_idx_d;
            rate_q         <= curr_data_rate_i;
            skp_os_q       <= skp_os_d;
            seed_pend_q    <= seed_pend_d;
            hdr_err_cnt_q  <= hdr_err_cnt_d;
            seed_load_q    <= seed_load_d;
            advance_q      <= advance_d;
            bypass_q       <= bypass_d;
            block_type_q   <= block_type_d;
            word_idx_out_q <= word_idx_d;
            aligned_q      <= aligned_d;
            hdr_err_q      <= hdr_err_d;
        end
    end

    assign seed_load_o   = seed_load_q;
    assign advance_o     = advance_q;
    assign bypass_o      = bypass_q;
    assign block_type_o  = block_type_q;
    assign word_idx_o    = word_idx_out_q;
    assign aligned_o     = aligned_q;
    assign hdr_err_o     = hdr_err_q;
    assign hdr_err_cnt_o = hdr_err_cnt_q;

endmodule
